// File: rtl/scl_sda_detector_if.sv
// Pin and event bundle between the I2C pads and the slave front end.
// The detector takes the slave side; the pad/bench side takes master.
interface scl_sda_detector_if;
   logic scl_in;
   logic sda_in;
   logic scl_filt;
   logic sda_filt;
   logic rising_edge;
   logic falling_edge;
   logic start_found;
   logic stop_found;
   logic bus_busy;

   modport master (
      output scl_in, sda_in,
      input  scl_filt, sda_filt,
      input  rising_edge, falling_edge,
      input  start_found, stop_found,
      input  bus_busy
   );

   modport slave (
      input  scl_in, sda_in,
      output scl_filt, sda_filt,
      output rising_edge, falling_edge,
      output start_found, stop_found,
      output bus_busy
   );
endinterface

// File: rtl/scl_sda_detector.sv
// I2C slave front end: sync, glitch filter, SCL edge and START/STOP
// pulses, and a bus-busy flag.
module scl_sda_detector #(
   parameter int FILTER_CYCLES = 3
) (
   input logic clk,
   input logic n_rst,
   scl_sda_detector_if.slave bus
);

   localparam logic [3:0] CNT_MAX = 4'(FILTER_CYCLES - 1);

   typedef enum logic {IDLE, BUSY} state_t;

   logic scl_s1, scl_s2, sda_s1, sda_s2;
   logic scl_f, sda_f, scl_prev, sda_prev;
   logic [3:0] scl_cnt, sda_cnt;
   logic primed, armed;
   logic rise_q, fall_q, start_q, stop_q, busy_q;
   state_t state;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         scl_s1 <= 1'b1;
         scl_s2 <= 1'b1;
         sda_s1 <= 1'b1;
         sda_s2 <= 1'b1;
      end else begin
         scl_s1 <= bus.scl_in;
         scl_s2 <= scl_s1;
         sda_s1 <= bus.sda_in;
         sda_s2 <= sda_s1;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         scl_f   <= 1'b1;
         scl_cnt <= '0;
      end else if (scl_s2 == scl_f) begin
         scl_cnt <= '0;
      end else if (scl_cnt == CNT_MAX) begin
         scl_f   <= scl_s2;
         scl_cnt <= '0;
      end else begin
         scl_cnt <= scl_cnt + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         sda_f   <= 1'b1;
         sda_cnt <= '0;
      end else if (sda_s2 == sda_f) begin
         sda_cnt <= '0;
      end else if (sda_cnt == CNT_MAX) begin
         sda_f   <= sda_s2;
         sda_cnt <= '0;
      end else begin
         sda_cnt <= sda_cnt + 4'd1;
      end
   end

   // The reset-time 1s in the sync chain are not real samples, so arming
   // waits until genuine pin values have reached s1 and everything is high.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         primed <= 1'b0;
         armed  <= 1'b0;
      end else begin
         primed <= 1'b1;
         if (primed && scl_s1 && scl_s2 && sda_s1 && sda_s2 &&
             scl_f && sda_f && scl_prev && sda_prev)
            armed <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         scl_prev <= 1'b1;
         sda_prev <= 1'b1;
         rise_q   <= 1'b0;
         fall_q   <= 1'b0;
         start_q  <= 1'b0;
         stop_q   <= 1'b0;
      end else begin
         scl_prev <= scl_f;
         sda_prev <= sda_f;
         rise_q   <= scl_f & ~scl_prev;
         fall_q   <= ~scl_f & scl_prev;
         start_q  <= armed & scl_f & scl_prev & ~sda_f & sda_prev;
         stop_q   <= armed & scl_f & scl_prev & sda_f & ~sda_prev;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state  <= IDLE;
         busy_q <= 1'b0;
      end else begin
         unique case (state)
            IDLE: if (start_q) begin
               state  <= BUSY;
               busy_q <= 1'b1;
            end
            BUSY: if (stop_q) begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.scl_filt     = scl_f;
   assign bus.sda_filt     = sda_f;
   assign bus.rising_edge  = rise_q;
   assign bus.falling_edge = fall_q;
   assign bus.start_found  = start_q;
   assign bus.stop_found   = stop_q;
   assign bus.bus_busy     = busy_q;

endmodule

// File: tb/tb_scl_sda_detector.sv
// Directed bench for scl_sda_detector; expected pulses are queued with
// their due cycle when pins are driven and matched as the DUT emits them.
module tb_scl_sda_detector;

   localparam int F   = 3;
   localparam int LAT = 2 + F;
   localparam int RISE = 0, FALL = 1, START = 2, STOP = 3;

   typedef struct {
      int kind;
      int cyc;
   } ev_t;

   logic clk;
   logic n_rst;
   int   cyc;
   int   n_assert;
   int   fails;
   int   rise_cnt, fall_cnt;
   ev_t  q[$];

   scl_sda_detector_if bus ();

   scl_sda_detector #(.FILTER_CYCLES(F)) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Called just before the pins are driven, after a posedge.
   task automatic expect_ev(input int kind);
      ev_t e;
      e.kind = kind;
      e.cyc  = cyc + 1 + LAT;
      q.push_back(e);
   endtask

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_assert++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%b expected=%b cyc=%0d", tag, obs, exp, cyc);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      n_assert++;
      assert (obs == exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_ev(input int kind);
      ev_t e;
      n_assert++;
      assert (q.size() != 0) else begin
         fails++;
         $error("FAIL sb_unexpected observed=kind%0d@%0d expected=none",
                kind, cyc);
      end
      if (q.size() != 0) begin
         e = q.pop_front();
         n_assert++;
         assert (e.kind == kind && e.cyc == cyc) else begin
            fails++;
            $error("FAIL sb_event observed=kind%0d@%0d expected=kind%0d@%0d",
                   kind, cyc, e.kind, e.cyc);
         end
      end
   endtask

   always @(negedge clk) begin
      if (bus.rising_edge) begin
         rise_cnt++;
         check_ev(RISE);
      end
      if (bus.falling_edge) begin
         fall_cnt++;
         check_ev(FALL);
      end
      if (bus.start_found) check_ev(START);
      if (bus.stop_found)  check_ev(STOP);
   end

   initial begin
      logic [7:0] data;
      logic       b;
      int         r0, f0;
      n_assert = 0;
      fails    = 0;
      rise_cnt = 0;
      fall_cnt = 0;
      data     = 8'hA5;
      n_rst      = 1'b0;
      bus.scl_in = 1'b1;
      bus.sda_in = 1'b1;

      // reset state
      tick(3);
      chk("rst_scl_filt", bus.scl_filt, 1'b1);
      chk("rst_sda_filt", bus.sda_filt, 1'b1);
      chk("rst_rise", bus.rising_edge, 1'b0);
      chk("rst_fall", bus.falling_edge, 1'b0);
      chk("rst_start", bus.start_found, 1'b0);
      chk("rst_stop", bus.stop_found, 1'b0);
      chk("rst_busy", bus.bus_busy, 1'b0);
      n_rst = 1'b1;
      tick(10);

      // SCL fall latency
      expect_ev(FALL);
      bus.scl_in = 1'b0;
      tick(4);
      chk("t1_filt_before", bus.scl_filt, 1'b1);
      tick(1);
      chk("t1_filt_after", bus.scl_filt, 1'b0);
      tick(15);
      expect_ev(RISE);
      bus.scl_in = 1'b1;
      tick(10);

      // glitches
      bus.scl_in = 1'b0;
      tick(2);
      bus.scl_in = 1'b1;
      tick(10);
      chk("t2_glitch2_filt", bus.scl_filt, 1'b1);
      expect_ev(FALL);
      bus.scl_in = 1'b0;
      tick(3);
      expect_ev(RISE);
      bus.scl_in = 1'b1;
      tick(10);

      // START / STOP and bus_busy timing
      expect_ev(START);
      bus.sda_in = 1'b0;
      tick(6);
      chk("t3_busy_pre", bus.bus_busy, 1'b0);
      tick(1);
      chk("t3_busy_set", bus.bus_busy, 1'b1);
      tick(10);
      expect_ev(STOP);
      bus.sda_in = 1'b1;
      tick(6);
      chk("t3_busy_hold", bus.bus_busy, 1'b1);
      tick(1);
      chk("t3_busy_clr", bus.bus_busy, 1'b0);
      tick(10);

      // byte 0xA5 plus ACK, repeated START, STOP
      expect_ev(START);
      bus.sda_in = 1'b0;
      tick(10);
      r0 = rise_cnt;
      f0 = fall_cnt;
      for (int i = 0; i < 9; i++) begin
         b = (i < 8) ? data[7 - i] : 1'b0;
         expect_ev(FALL);
         bus.scl_in = 1'b0;
         tick(6);
         bus.sda_in = b;
         tick(6);
         expect_ev(RISE);
         bus.scl_in = 1'b1;
         tick(8);
      end
      chk_int("t4_rise_count", rise_cnt - r0, 9);
      chk_int("t4_fall_count", fall_cnt - f0, 9);
      chk("t4_busy_frame", bus.bus_busy, 1'b1);
      expect_ev(FALL);
      bus.scl_in = 1'b0;
      tick(6);
      bus.sda_in = 1'b1;
      tick(6);
      expect_ev(RISE);
      bus.scl_in = 1'b1;
      tick(8);
      expect_ev(START);
      bus.sda_in = 1'b0;
      tick(10);
      chk("t4_busy_rstart", bus.bus_busy, 1'b1);
      expect_ev(FALL);
      bus.scl_in = 1'b0;
      tick(6);
      expect_ev(RISE);
      bus.scl_in = 1'b1;
      tick(8);
      expect_ev(STOP);
      bus.sda_in = 1'b1;
      tick(10);
      chk("t4_busy_end", bus.bus_busy, 1'b0);

      // simultaneous SCL/SDA changes
      expect_ev(FALL);
      bus.scl_in = 1'b0;
      bus.sda_in = 1'b0;
      tick(10);
      expect_ev(RISE);
      bus.scl_in = 1'b1;
      bus.sda_in = 1'b1;
      tick(10);
      chk("t5_busy", bus.bus_busy, 1'b0);

      // reset mid-frame, released with SDA low
      expect_ev(START);
      bus.sda_in = 1'b0;
      tick(10);
      chk("t6_busy_pre", bus.bus_busy, 1'b1);
      n_rst = 1'b0;
      tick(2);
      chk("t6_rst_busy", bus.bus_busy, 1'b0);
      chk("t6_rst_sda_filt", bus.sda_filt, 1'b1);
      n_rst = 1'b1;
      tick(20);
      chk("t6_no_start_busy", bus.bus_busy, 1'b0);
      chk("t6_sda_filt_low", bus.sda_filt, 1'b0);
      bus.sda_in = 1'b1;
      tick(12);
      expect_ev(START);
      bus.sda_in = 1'b0;
      tick(10);
      chk("t6_busy_post", bus.bus_busy, 1'b1);

      tick(5);
      chk_int("sb_drained", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, fails);
      $finish;
   end

endmodule
